// File: rtl/hist_eq_core.sv
// Frame histogram equalizer: buffer a frame while binning it, build CDF and
// equalization LUT in place, then stream the remapped frame out in order.
module hist_eq_core #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_gray,
  input  logic       i_end,
  output logic       o_in_ready,
  input  logic       i_out_ready,
  output logic       o_valid,
  output logic [7:0] o_gray_eq,
  output logic       o_done
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW    = CW + 8;
  localparam int SW    = $clog2(PW);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

  typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_CDF, S_LUT, S_OUT, S_DONE} state_t;

  state_t          state, state_nx;
  logic [7:0]      addr;
  logic [CW-1:0]   n, k, acc, cdf_min;
  logic            found;
  logic [PW-1:0]   quo;
  logic [CW-1:0]   rem;
  logic [SW-1:0]   step;
  logic            div_busy;

  logic [7:0]      frame_buf [TOTAL];
  logic [CW-1:0]   hist [256];
  logic [7:0]      lut [256];

  logic            accept, last_in, xfer;
  logic [CW-1:0]   bin_cur, cdf_next, den, diff;
  logic [PW-1:0]   numer, quo_nx;
  logic [CW:0]     rem_sh;
  logic [CW-1:0]   rem_nx;
  logic            ge, div_last;
  logic            hist_we, lut_we;
  logic [7:0]      hist_waddr, lut_wdata;
  logic [CW-1:0]   hist_wdata;

  assign accept   = (state == S_ACCUM) && o_in_ready && i_valid;
  assign last_in  = accept && (i_end || (n == TOTAL_C - CW'(1)));
  assign xfer     = o_valid && i_out_ready;
  assign bin_cur  = hist[addr];
  assign cdf_next = acc + bin_cur;
  assign den      = n - cdf_min;
  assign diff     = bin_cur - cdf_min;
  // Rounded half up: add den/2 before the divide.
  assign numer    = PW'(diff) * PW'(255) + PW'(den >> 1);

  // Restoring divider, one quotient bit per cycle, dividend shifted out of quo.
  assign rem_sh   = {rem, quo[PW-1]};
  assign ge       = rem_sh >= {1'b0, den};
  assign rem_nx   = ge ? CW'(rem_sh - {1'b0, den}) : rem_sh[CW-1:0];
  assign quo_nx   = {quo[PW-2:0], ge};
  assign div_last = div_busy && (step == SW'(PW - 1));

  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = addr;
    hist_wdata = '0;
    case (state)
      S_CLEAR: hist_we = 1'b1;
      S_ACCUM: begin
        hist_we    = accept;
        hist_waddr = i_gray;
        hist_wdata = hist[i_gray] + CW'(1);
      end
      S_CDF: begin
        hist_we    = 1'b1;
        hist_wdata = cdf_next;
      end
      default: ;
    endcase
  end

  always_comb begin
    lut_we    = 1'b0;
    lut_wdata = '0;
    if (state == S_LUT) begin
      if (div_busy) begin
        lut_we    = div_last;
        lut_wdata = (|quo_nx[PW-1:8]) ? 8'hFF : quo_nx[7:0];
      end else if (den == '0) begin
        lut_we    = 1'b1;
        lut_wdata = addr;
      end else if (bin_cur < cdf_min) begin
        lut_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: if (addr == 8'hFF) state_nx = S_ACCUM;
      S_ACCUM: if (last_in) state_nx = S_CDF;
      S_CDF:   if (addr == 8'hFF) state_nx = S_LUT;
      S_LUT:   if (lut_we && addr == 8'hFF) state_nx = S_OUT;
      S_OUT:   if (xfer && k == n) state_nx = S_DONE;
      S_DONE:  state_nx = S_CLEAR;
      default: state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr       <= '0;
      n          <= '0;
      k          <= '0;
      acc        <= '0;
      cdf_min    <= '0;
      found      <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      step       <= '0;
      div_busy   <= 1'b0;
      o_in_ready <= 1'b0;
      o_valid    <= 1'b0;
      o_gray_eq  <= '0;
      o_done     <= 1'b0;
    end else begin
      o_in_ready <= (state_nx == S_ACCUM);
      o_done     <= (state_nx == S_DONE);
      case (state)
        S_CLEAR: begin
          addr    <= addr + 8'd1;
          n       <= '0;
          k       <= '0;
          acc     <= '0;
          cdf_min <= '0;
          found   <= 1'b0;
        end
        S_ACCUM: if (accept) n <= n + CW'(1);
        S_CDF: begin
          addr <= addr + 8'd1;
          acc  <= cdf_next;
          if (!found && bin_cur != '0) begin
            found   <= 1'b1;
            cdf_min <= cdf_next;
          end
        end
        S_LUT: begin
          if (div_busy) begin
            quo  <= quo_nx;
            rem  <= rem_nx;
            step <= step + SW'(1);
            if (div_last) begin
              div_busy <= 1'b0;
              addr     <= addr + 8'd1;
            end
          end else if (lut_we) begin
            addr <= addr + 8'd1;
          end else begin
            quo      <= numer;
            rem      <= '0;
            step     <= '0;
            div_busy <= 1'b1;
          end
        end
        S_OUT: begin
          // Output register refills whenever it is empty or being drained.
          if (!o_valid || i_out_ready) begin
            if (k != n) begin
              o_valid   <= 1'b1;
              o_gray_eq <= lut[frame_buf[k[AW-1:0]]];
              k         <= k + CW'(1);
            end else begin
              o_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept)  frame_buf[n[AW-1:0]] <= i_gray;
    if (hist_we) hist[hist_waddr]     <= hist_wdata;
    if (lut_we)  lut[addr]            <= lut_wdata;
  end
endmodule

// File: tb/tb_hist_eq_core.sv
// Directed bench for hist_eq_core on a 16x16 frame (256 pixels).
module tb_hist_eq_core;
  localparam int W = 16, H = 16, TOT = W * H;

  logic       i_clk = 1'b0, i_rst = 1'b1;
  logic       i_valid = 1'b0, i_end = 1'b0, i_out_ready = 1'b0;
  logic [7:0] i_gray = '0;
  logic       o_in_ready, o_valid, o_done;
  logic [7:0] o_gray_eq;

  hist_eq_core #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_gray(i_gray),
    .i_end(i_end), .o_in_ready(o_in_ready), .i_out_ready(i_out_ready),
    .o_valid(o_valid), .o_gray_eq(o_gray_eq), .o_done(o_done));

  always #5 i_clk = ~i_clk;

  int tests = 0, fails = 0;
  logic [7:0] pix [TOT];
  logic [7:0] expv [TOT];
  logic [7:0] got [TOT];

  task automatic wait_in_ready(output int cyc);
    bit seen;
    seen = 0; cyc = 0;
    while (!seen && cyc < 2000) begin
      @(posedge i_clk); #1; cyc++;
      if (o_in_ready) seen = 1;
    end
    if (!seen) cyc = -1;
  endtask

  task automatic send(input int cnt, input bit use_end);
    for (int i = 0; i < cnt; i++) begin
      i_valid = 1'b1; i_gray = pix[i]; i_end = use_end && (i == cnt - 1);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_end = 1'b0;
  endtask

  task automatic recv(input int cnt, input bit rnd, output int n_got, output int extra,
                      output int unstable, output int dones, output bit tmo);
    int cyc, tail;
    bit pv, pr, v, r;
    logic [7:0] pd, d;
    n_got = 0; extra = 0; unstable = 0; dones = 0; tmo = 0;
    cyc = 0; tail = 0; pv = 0; pr = 0; pd = '0;
    while (tail < 8 && !tmo) begin
      v = o_valid; d = o_gray_eq;
      if (o_done) dones++;
      if (pv && !pr && (v !== 1'b1 || d !== pd)) unstable++;
      r = (n_got >= cnt || !rnd) ? 1'b1 : ($urandom_range(0, 1) == 1);
      i_out_ready = r;
      if (v && r) begin
        if (n_got < cnt) begin got[n_got] = d; n_got++; end
        else extra++;
      end
      pv = v; pr = r; pd = d;
      if (n_got >= cnt) tail++;
      cyc++;
      if (cyc > 20000) tmo = 1;
      @(posedge i_clk); #1;
    end
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int cyc;
    repeat (3) @(posedge i_clk);
    #1;
    tests++; if (o_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", o_in_ready); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    tests++; if (o_gray_eq !== 8'd0) begin fails++; $display("FAIL reset_gray: got %0d expected 0", o_gray_eq); end
    tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", o_done); end
    i_rst = 1'b0;
    wait_in_ready(cyc);
    tests++; if (cyc != 256) begin fails++; $display("FAIL clear_cycles: got %0d expected 256", cyc); end
  endtask

  task automatic test_ramp(input bit rnd);
    int cyc, n_got, extra, unst, dones; bit tmo, bad;
    if (!o_in_ready) wait_in_ready(cyc);
    for (int i = 0; i < TOT; i++) begin pix[i] = 8'(i); expv[i] = 8'(i); end
    send(TOT, 1'b0);
    tests++; if (o_in_ready !== 1'b0) begin fails++; $display("FAIL ramp_in_ready_drop: got %b expected 0", o_in_ready); end
    recv(TOT, rnd, n_got, extra, unst, dones, tmo);
    tests++; if (tmo || n_got != TOT) begin fails++; $display("FAIL ramp_count rnd=%0d: got %0d expected %0d", rnd, n_got, TOT); end
    bad = 0;
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got[i] !== expv[i]) begin fails++; if (!bad) $display("FAIL ramp_pixel[%0d]: got %0d expected %0d", i, got[i], expv[i]); bad = 1; end
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL ramp_extra: got %0d expected 0", extra); end
    tests++; if (dones != 1) begin fails++; $display("FAIL ramp_done_pulses: got %0d expected 1", dones); end
    if (rnd) begin
      tests++; if (unst != 0) begin fails++; $display("FAIL ramp_stall_stable: got %0d changes expected 0", unst); end
    end
  endtask

  task automatic test_two_level;
    int cyc, n_got, extra, unst, dones; bit tmo, bad;
    wait_in_ready(cyc);
    for (int i = 0; i < TOT; i++) begin
      pix[i]  = (i < TOT / 2) ? 8'd10 : 8'd200;
      expv[i] = (i < TOT / 2) ? 8'd0 : 8'd255;
    end
    send(TOT, 1'b0);
    recv(TOT, 1'b0, n_got, extra, unst, dones, tmo);
    tests++; if (tmo || n_got != TOT) begin fails++; $display("FAIL two_level_count: got %0d expected %0d", n_got, TOT); end
    bad = 0;
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got[i] !== expv[i]) begin fails++; if (!bad) $display("FAIL two_level_pixel[%0d]: got %0d expected %0d", i, got[i], expv[i]); bad = 1; end
    end
    tests++; if (dones != 1) begin fails++; $display("FAIL two_level_done: got %0d expected 1", dones); end
  endtask

  task automatic test_constant;
    int cyc, n_got, extra, unst, dones; bit tmo, bad;
    wait_in_ready(cyc);
    for (int i = 0; i < TOT; i++) begin pix[i] = 8'd77; expv[i] = 8'd77; end
    send(TOT, 1'b0);
    recv(TOT, 1'b0, n_got, extra, unst, dones, tmo);
    tests++; if (tmo || n_got != TOT) begin fails++; $display("FAIL constant_count: got %0d expected %0d", n_got, TOT); end
    bad = 0;
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got[i] !== 8'd77) begin fails++; if (!bad) $display("FAIL constant_pixel[%0d]: got %0d expected 77", i, got[i]); bad = 1; end
    end
  endtask

  task automatic test_short_frame;
    int cyc, n_got, extra, unst, dones; bit tmo;
    logic [7:0] vals [4];
    logic [7:0] outs [4];
    vals = '{8'd0, 8'd0, 8'd1, 8'd3};
    outs = '{8'd0, 8'd0, 8'd128, 8'd255};
    wait_in_ready(cyc);
    for (int i = 0; i < 4; i++) pix[i] = vals[i];
    send(4, 1'b1);
    tests++; if (o_in_ready !== 1'b0) begin fails++; $display("FAIL short_in_ready_drop: got %b expected 0", o_in_ready); end
    // Beats after the end marker must not reach the histogram or buffer.
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_gray = 8'd255; @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    recv(4, 1'b0, n_got, extra, unst, dones, tmo);
    tests++; if (tmo || n_got != 4) begin fails++; $display("FAIL short_count: got %0d expected 4", n_got); end
    for (int i = 0; i < n_got; i++) begin
      tests++;
      if (got[i] !== outs[i]) begin fails++; $display("FAIL short_pixel[%0d]: got %0d expected %0d", i, got[i], outs[i]); end
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL short_extra: got %0d expected 0", extra); end
    tests++; if (dones != 1) begin fails++; $display("FAIL short_done: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_during_out;
    int cyc; bit seen;
    wait_in_ready(cyc);
    for (int i = 0; i < TOT; i++) pix[i] = 8'(255 - i);
    send(TOT, 1'b0);
    seen = 0; cyc = 0;
    while (!seen && cyc < 20000) begin @(posedge i_clk); #1; cyc++; if (o_valid) seen = 1; end
    tests++; if (!seen) begin fails++; $display("FAIL rst_out_reach: got no o_valid expected o_valid"); end
    i_out_ready = 1'b1;
    repeat (10) @(posedge i_clk);
    #2; i_rst = 1'b1; #1;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", o_valid); end
    tests++; if (o_gray_eq !== 8'd0) begin fails++; $display("FAIL rst_out_gray: got %0d expected 0", o_gray_eq); end
    tests++; if (o_in_ready !== 1'b0) begin fails++; $display("FAIL rst_out_in_ready: got %b expected 0", o_in_ready); end
    tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL rst_out_done: got %b expected 0", o_done); end
    i_out_ready = 1'b0;
    @(posedge i_clk); #1; i_rst = 1'b0;
    wait_in_ready(cyc);
    tests++; if (cyc != 256) begin fails++; $display("FAIL rst_out_clear_cycles: got %0d expected 256", cyc); end
    test_ramp(1'b0);
  endtask

  initial begin
    test_reset;
    test_ramp(1'b0);
    test_two_level;
    test_constant;
    test_short_frame;
    test_ramp(1'b1);
    test_reset_during_out;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hist_eq_core.md
Name: hist_eq_core

Overview:
Frame-based 8-bit grayscale histogram equalizer. It buffers one full frame while building a 256-bin histogram, then computes the CDF and the equalization LUT. It then streams the remapped pixels out, in input order, over a ready/valid interface. It sits between a gray-conversion stage and a display/sink stage.

Parameters:
WIDTH, 320, frame width in pixels
HEIGHT, 240, frame height in pixels
(derived) TOTAL = WIDTH*HEIGHT; CW = clog2(TOTAL+1) bits for counts

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input pixel valid
i_gray  in  8  input pixel
i_end  in  1  marks last pixel of frame, qualified by i_valid
o_in_ready  out  1  block accepts input pixels
i_out_ready  in  1  downstream ready
o_valid  out  1  output pixel valid
o_gray_eq  out  8  equalized pixel
o_done  out  1  one-cycle pulse, frame output complete

Behaviour:
- One clock, i_clk; reset is asynchronous and active-high (i_rst). All outputs are registered.
- Reset values: o_in_ready=0, o_valid=0, o_gray_eq=0, o_done=0. State goes to CLEAR and all counters go to 0.
- Reset asserted mid-operation aborts the frame; the next frame starts from CLEAR.
- Storage:
  - frame buffer TOTAL x 8
  - histogram 256 x CW
  - LUT 256 x 8
- States: CLEAR -> ACCUM -> CDF -> LUT -> OUT -> DONE -> CLEAR.
- CLEAR: zero the 256 histogram bins, one per cycle (256 cycles); o_in_ready=0.
- ACCUM:
  - o_in_ready=1 throughout.
  - Every cycle with i_valid=1 accepts a pixel: write it to frame_buf[n], increment hist[i_gray], increment n.
  - Back-to-back identical values must count correctly (forwarding or a combinational-read array).
  - Leave ACCUM after accepting a pixel with i_end=1, or when n reaches TOTAL, whichever comes first.
  - Beats after leaving are ignored; o_in_ready drops the cycle after the last accept.
  - N = number of accepted pixels.
- CDF:
  - Walk the bins 0..255, cdf[v] = sum of hist[0..v], stored in place.
  - cdf_min = cdf of the first bin with nonzero count.
- LUT:
  - den = N - cdf_min.
  - If den = 0 (single-valued frame): LUT[v] = v (identity).
  - Otherwise LUT[v] = ((cdf[v]-cdf_min)*255 + den/2) / den, integer division, rounded half up, saturated to 255.
  - Bins with cdf[v] < cdf_min give 0.
  - Use a sequential divider; LUT build latency is unconstrained.
- OUT:
  - For k = 0..N-1: fetch frame_buf[k], present o_gray_eq = LUT[pixel], o_valid=1.
  - o_valid and o_gray_eq hold stable until o_valid&&i_out_ready (transfer), then advance.
  - Throughput at least one pixel per 2 cycles while ready stays high. No drop, no duplicate, order preserved.
- DONE: o_done=1 for exactly one cycle after the last transfer; o_valid=0; then go to CLEAR for the next frame.
- Count arithmetic is CW bits; the LUT product needs CW+8 bits.

Test Plan:
- Ramp frame 320x240, pixel i = i mod 256 -> each bin 300, cdf_min=300, output equals input for all 76800 pixels, then o_done pulses once.
- Two-level frame: first 38400 pixels 10, rest 200 -> outputs 0 for the 10 pixels and 255 for the 200 pixels, in the same positions.
- Constant frame of 77 -> den=0 -> every output is 77.
- WIDTH=4, HEIGHT=2, frame {0,0,1,3} with i_end on the 4th pixel -> N=4; outputs 0,0,128,255; extra i_valid beats after i_end are ignored.
- Ramp frame with i_out_ready randomized each cycle -> every transfer matches expected in order; o_gray_eq stays stable while o_valid=1 and i_out_ready=0.
- Assert i_rst during OUT -> outputs go to reset values immediately. After release, CLEAR runs for 256 cycles, then o_in_ready=1 and a fresh ramp frame equalizes correctly.
